// File: rtl/rf_exec_ctrl.sv
// Single-issue execution controller placed in front of an 8x8 register file.
// It accepts one instruction at a time, drives the read addresses, computes
// an ALU result (or a shift-add multiply over eight cycles), then writes the
// result back through WEN/RW/busW.
module rf_exec_ctrl #(
  parameter int DW = 8,
  parameter int AW = 3,
  parameter int IW = 12
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_instr,
  output logic [AW-1:0] RX,
  output logic [AW-1:0] RY,
  input  logic [DW-1:0] busX,
  input  logic [DW-1:0] busY,
  output logic          WEN,
  output logic [AW-1:0] RW,
  output logic [DW-1:0] busW,
  output logic          carry,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_LDI = 3'd7;

  state_t        state_reg, state_next;
  logic [2:0]    op_reg, op_next;
  logic [AW-1:0] rd_reg, rd_next;
  logic [AW-1:0] rx_reg, rx_next;
  logic [AW-1:0] ry_reg, ry_next;
  logic [AW-1:0] rw_reg, rw_next;
  logic [DW-1:0] busw_reg, busw_next;
  logic          carry_reg, carry_next;
  logic [DW-1:0] mcand_reg, mcand_next;
  logic [DW-1:0] mplier_reg, mplier_next;
  logic [DW-1:0] acc_reg, acc_next;
  logic [2:0]    cnt_reg, cnt_next;

  // The top bit of the 9-bit difference is the unsigned borrow (busX < busY).
  logic [DW:0]   sum_w;
  logic [DW:0]   diff_w;
  logic [DW-1:0] addend_w;

  assign sum_w    = {1'b0, busX} + {1'b0, busY};
  assign diff_w   = {1'b0, busX} - {1'b0, busY};
  assign addend_w = mplier_reg[0] ? mcand_reg : '0;

  assign RX    = rx_reg;
  assign RY    = ry_reg;
  assign RW    = rw_reg;
  assign busW  = busw_reg;
  assign carry = carry_reg;

  // Next-state, datapath updates and handshake/write-strobe decode.
  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    rd_next     = rd_reg;
    rx_next     = rx_reg;
    ry_next     = ry_reg;
    rw_next     = rw_reg;
    busw_next   = busw_reg;
    carry_next  = carry_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    in_ready    = 1'b0;
    WEN         = 1'b0;
    done        = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_next    = in_instr[IW-1 -: 3];
          rd_next    = in_instr[3*AW-1 -: AW];
          rx_next    = in_instr[2*AW-1 -: AW];
          ry_next    = in_instr[AW-1:0];
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (op_reg == OP_MUL) begin
          mcand_next  = busX;
          mplier_next = busY;
          acc_next    = '0;
          cnt_next    = '0;
          state_next  = MUL;
        end else begin
          case (op_reg)
            OP_ADD: begin
              busw_next  = sum_w[DW-1:0];
              carry_next = sum_w[DW];
            end
            OP_SUB: begin
              busw_next  = diff_w[DW-1:0];
              carry_next = diff_w[DW];
            end
            OP_AND:  busw_next = busX & busY;
            OP_OR:   busw_next = busX | busY;
            OP_XOR:  busw_next = busX ^ busY;
            OP_SLL:  busw_next = busX << busY[2:0];
            // The immediate is carried in the captured rs/rt fields.
            OP_LDI:  busw_next = DW'({rx_reg, ry_reg});
            default: busw_next = busw_reg;
          endcase
          rw_next    = rd_reg;
          state_next = WB;
        end
      end
      MUL: begin
        acc_next    = acc_reg + addend_w;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + 3'd1;
        if (cnt_reg == 3'd7) begin
          busw_next  = acc_reg + addend_w;
          rw_next    = rd_reg;
          state_next = WB;
        end
      end
      WB: begin
        WEN        = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight instruction.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      rd_reg     <= '0;
      rx_reg     <= '0;
      ry_reg     <= '0;
      rw_reg     <= '0;
      busw_reg   <= '0;
      carry_reg  <= 1'b0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      rd_reg     <= rd_next;
      rx_reg     <= rx_next;
      ry_reg     <= ry_next;
      rw_reg     <= rw_next;
      busw_reg   <= busw_next;
      carry_reg  <= carry_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
    end
  end

endmodule
